// File: rtl/z80fi_insn_check_ld_ind_rr_a.sv
// ---------------------------------------------------------------------------
// z80fi_insn_check_ld_ind_rr_a
//
// Purpose:
//   Formal-interface style checker for the Z80 "LD (rr),A" instructions:
//     0x02 LD (BC),A   sel 0
//     0x12 LD (DE),A   sel 1
//     0x77 LD (HL),A   sel 2  (only when NUM_PTR == 3)
//   Each retired instruction is checked in a 2-stage pipeline. Stage 1
//   captures the expected write (pointer / accumulator / PC+1) next to the
//   actual write. Stage 2 compares them and produces a one-cycle result.
//   A sticky failure flag is held until chk_clear or reset.
//
// Configuration:
//   Z80FI_CHECK_STATS_EN - when defined, saturating pass/fail counters are
//                          built; otherwise pass_count/fail_count are 0.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   z80fi_valid       retired-instruction strobe
//   z80fi_insn        instruction bytes, opcode in [7:0]
//   z80fi_insn_len    instruction length in bytes
//   z80fi_pc_rdata    PC before execution
//   z80fi_pc_wdata    PC after execution
//   z80fi_ptr_rdata   selected pointer register value
//   z80fi_a_rdata     accumulator before execution
//   z80fi_mem_wr/waddr/wdata  actual memory write
//   chk_clear         clears sticky failure and counters
//   chk_valid         one-cycle check result strobe
//   chk_pass          check passed (0 when chk_valid is 0)
//   chk_fail          sticky failure flag
//   chk_ptr_sel       pointer select of the reported check
//   pass_count/fail_count  saturating statistics counters
// ---------------------------------------------------------------------------
module z80fi_insn_check_ld_ind_rr_a #(
    parameter int NUM_PTR = 2,
    parameter int ADDR_W  = 16,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              z80fi_valid,
    input  logic [31:0]       z80fi_insn,
    input  logic [2:0]        z80fi_insn_len,
    input  logic [ADDR_W-1:0] z80fi_pc_rdata,
    input  logic [ADDR_W-1:0] z80fi_pc_wdata,
    input  logic [ADDR_W-1:0] z80fi_ptr_rdata,
    input  logic [7:0]        z80fi_a_rdata,
    input  logic              z80fi_mem_wr,
    input  logic [ADDR_W-1:0] z80fi_mem_waddr,
    input  logic [7:0]        z80fi_mem_wdata,
    input  logic              chk_clear,
    output logic              chk_valid,
    output logic              chk_pass,
    output logic              chk_fail,
    output logic [1:0]        chk_ptr_sel,
    output logic [CNT_W-1:0]  pass_count,
    output logic [CNT_W-1:0]  fail_count
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_FAILED = 1'b1
    } state_t;

    // Only the first opcode byte matters for these single-byte instructions.
    logic w_unused_insn;
    assign w_unused_insn = ^z80fi_insn[31:8];

    // ---------------- decode ----------------
    logic       w_hit;
    logic [1:0] w_sel;

    always_comb begin
        w_hit = 1'b0;
        w_sel = 2'd0;
        if (z80fi_valid && (z80fi_insn_len == 3'd1)) begin
            case (z80fi_insn[7:0])
                8'h02: begin
                    w_hit = 1'b1;
                    w_sel = 2'd0;
                end
                8'h12: begin
                    w_hit = 1'b1;
                    w_sel = 2'd1;
                end
                8'h77: begin
                    if (NUM_PTR == 3) begin
                        w_hit = 1'b1;
                        w_sel = 2'd2;
                    end
                end
                default: begin
                    w_hit = 1'b0;
                end
            endcase
        end
    end

    // ---------------- stage 1: capture expected and actual ----------------
    logic              r_s1_valid;
    logic [1:0]        r_s1_sel;
    logic [ADDR_W-1:0] r_s1_exp_addr;
    logic [7:0]        r_s1_exp_data;
    logic [ADDR_W-1:0] r_s1_exp_pc;
    logic              r_s1_mem_wr;
    logic [ADDR_W-1:0] r_s1_waddr;
    logic [7:0]        r_s1_wdata;
    logic [ADDR_W-1:0] r_s1_pc;

    // Payload registers need no reset; r_s1_valid qualifies them.
    always_ff @(posedge clk) begin
        if (w_hit) begin
            r_s1_sel      <= w_sel;
            r_s1_exp_addr <= z80fi_ptr_rdata;
            r_s1_exp_data <= z80fi_a_rdata;
            // Truncation to ADDR_W gives the modulo wrap of PC+1.
            r_s1_exp_pc   <= z80fi_pc_rdata + {{(ADDR_W-1){1'b0}}, 1'b1};
            r_s1_mem_wr   <= z80fi_mem_wr;
            r_s1_waddr    <= z80fi_mem_waddr;
            r_s1_wdata    <= z80fi_mem_wdata;
            r_s1_pc       <= z80fi_pc_wdata;
        end
    end

    // ---------------- stage 2: compare ----------------
    logic w_match;
    assign w_match = r_s1_mem_wr
                  && (r_s1_waddr == r_s1_exp_addr)
                  && (r_s1_wdata == r_s1_exp_data)
                  && (r_s1_pc    == r_s1_exp_pc);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            chk_valid   <= 1'b0;
            chk_pass    <= 1'b0;
            chk_ptr_sel <= 2'd0;
        end else begin
            r_s1_valid <= w_hit;
            chk_valid  <= r_s1_valid;
            chk_pass   <= r_s1_valid && w_match;
            if (r_s1_valid) begin
                chk_ptr_sel <= r_s1_sel;
            end
        end
    end

    // ---------------- sticky failure FSM ----------------
    state_t r_state;

    // chk_clear wins over a same-cycle failing result, so that result is
    // reported on chk_valid/chk_pass but never latched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (!chk_clear && chk_valid && !chk_pass) begin
                        r_state <= ST_FAILED;
                    end
                end
                ST_FAILED: begin
                    if (chk_clear) begin
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign chk_fail = (r_state == ST_FAILED);

    // ---------------- statistics ----------------
`ifdef Z80FI_CHECK_STATS_EN
    logic [CNT_W-1:0] r_pass_count;
    logic [CNT_W-1:0] r_fail_count;

    always_ff @(posedge clk) begin
        if (reset || chk_clear) begin
            r_pass_count <= '0;
            r_fail_count <= '0;
        end else if (chk_valid) begin
            if (chk_pass) begin
                if (r_pass_count != '1) begin
                    r_pass_count <= r_pass_count + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end else begin
                if (r_fail_count != '1) begin
                    r_fail_count <= r_fail_count + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign pass_count = r_pass_count;
    assign fail_count = r_fail_count;
`else
    assign pass_count = '0;
    assign fail_count = '0;
`endif

endmodule

// File: tb/tb_z80fi_insn_check_ld_ind_rr_a.sv
// ---------------------------------------------------------------------------
// tb_z80fi_insn_check_ld_ind_rr_a
//
// Directed bench for z80fi_insn_check_ld_ind_rr_a. Two instances share the
// stimulus: u_dut2 (NUM_PTR=2, CNT_W=16) and u_dut3 (NUM_PTR=3, CNT_W=2).
// Counter expectations are zero unless Z80FI_CHECK_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_z80fi_insn_check_ld_ind_rr_a;

`ifdef Z80FI_CHECK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        z80fi_valid;
    logic [31:0] z80fi_insn;
    logic [2:0]  z80fi_insn_len;
    logic [15:0] z80fi_pc_rdata;
    logic [15:0] z80fi_pc_wdata;
    logic [15:0] z80fi_ptr_rdata;
    logic [7:0]  z80fi_a_rdata;
    logic        z80fi_mem_wr;
    logic [15:0] z80fi_mem_waddr;
    logic [7:0]  z80fi_mem_wdata;
    logic        chk_clear;

    logic        d2_valid, d2_pass, d2_fail;
    logic [1:0]  d2_sel;
    logic [15:0] d2_pcnt, d2_fcnt;
    logic        d3_valid, d3_pass, d3_fail;
    logic [1:0]  d3_sel;
    logic [1:0]  d3_pcnt, d3_fcnt;

    int unsigned vectors;
    int unsigned miscompares;

    z80fi_insn_check_ld_ind_rr_a #(.NUM_PTR(2), .ADDR_W(16), .CNT_W(16)) u_dut2 (
        .clk(clk), .reset(reset), .z80fi_valid(z80fi_valid), .z80fi_insn(z80fi_insn),
        .z80fi_insn_len(z80fi_insn_len), .z80fi_pc_rdata(z80fi_pc_rdata),
        .z80fi_pc_wdata(z80fi_pc_wdata), .z80fi_ptr_rdata(z80fi_ptr_rdata),
        .z80fi_a_rdata(z80fi_a_rdata), .z80fi_mem_wr(z80fi_mem_wr),
        .z80fi_mem_waddr(z80fi_mem_waddr), .z80fi_mem_wdata(z80fi_mem_wdata),
        .chk_clear(chk_clear), .chk_valid(d2_valid), .chk_pass(d2_pass),
        .chk_fail(d2_fail), .chk_ptr_sel(d2_sel), .pass_count(d2_pcnt), .fail_count(d2_fcnt)
    );

    z80fi_insn_check_ld_ind_rr_a #(.NUM_PTR(3), .ADDR_W(16), .CNT_W(2)) u_dut3 (
        .clk(clk), .reset(reset), .z80fi_valid(z80fi_valid), .z80fi_insn(z80fi_insn),
        .z80fi_insn_len(z80fi_insn_len), .z80fi_pc_rdata(z80fi_pc_rdata),
        .z80fi_pc_wdata(z80fi_pc_wdata), .z80fi_ptr_rdata(z80fi_ptr_rdata),
        .z80fi_a_rdata(z80fi_a_rdata), .z80fi_mem_wr(z80fi_mem_wr),
        .z80fi_mem_waddr(z80fi_mem_waddr), .z80fi_mem_wdata(z80fi_mem_wdata),
        .chk_clear(chk_clear), .chk_valid(d3_valid), .chk_pass(d3_pass),
        .chk_fail(d3_fail), .chk_ptr_sel(d3_sel), .pass_count(d3_pcnt), .fail_count(d3_fcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_insn(input logic [7:0] op, input logic [2:0] len,
                            input logic [15:0] ptr, input logic [7:0] a,
                            input logic [15:0] pc_r, input logic [15:0] pc_w,
                            input logic wr, input logic [15:0] waddr,
                            input logic [7:0] wdata);
        z80fi_valid     = 1'b1;
        z80fi_insn      = {24'hA5A5A5, op};
        z80fi_insn_len  = len;
        z80fi_ptr_rdata = ptr;
        z80fi_a_rdata   = a;
        z80fi_pc_rdata  = pc_r;
        z80fi_pc_wdata  = pc_w;
        z80fi_mem_wr    = wr;
        z80fi_mem_waddr = waddr;
        z80fi_mem_wdata = wdata;
    endtask

    task automatic idle();
        z80fi_valid  = 1'b0;
        z80fi_mem_wr = 1'b0;
    endtask

    task automatic pulse_clear();
        chk_clear = 1'b1;
        tick();
        chk_clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        vectors++;
        if ({d2_valid, d2_pass, d2_fail, d2_sel, d2_pcnt, d2_fcnt} !== 37'd0) begin
            miscompares++;
            $display("FAIL reset_dut2 got %h expected 0", {d2_valid, d2_pass, d2_fail, d2_sel, d2_pcnt, d2_fcnt});
        end
        vectors++;
        if ({d3_valid, d3_pass, d3_fail, d3_sel, d3_pcnt, d3_fcnt} !== 9'd0) begin
            miscompares++;
            $display("FAIL reset_dut3 got %h expected 0", {d3_valid, d3_pass, d3_fail, d3_sel, d3_pcnt, d3_fcnt});
        end
    endtask

    task automatic test_pass_bc();
        set_insn(8'h02, 3'd1, 16'h1234, 8'h5A, 16'h0100, 16'h0101, 1'b1, 16'h1234, 8'h5A);
        tick();
        idle();
        vectors++;
        if (d2_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bc_latency got valid=%b expected 0", d2_valid);
        end
        tick();
        vectors++;
        if ({d2_valid, d2_pass, d2_sel} !== 4'b1100) begin
            miscompares++;
            $display("FAIL bc_pass_dut2 got %b expected 1100", {d2_valid, d2_pass, d2_sel});
        end
        vectors++;
        if ({d3_valid, d3_pass, d3_sel} !== 4'b1100) begin
            miscompares++;
            $display("FAIL bc_pass_dut3 got %b expected 1100", {d3_valid, d3_pass, d3_sel});
        end
        tick();
        vectors++;
        if ({d2_valid, d2_pass, d2_fail} !== 3'b000) begin
            miscompares++;
            $display("FAIL bc_one_pulse got %b expected 000", {d2_valid, d2_pass, d2_fail});
        end
        vectors++;
        if (d2_pcnt !== (STATS ? 16'd1 : 16'd0)) begin
            miscompares++;
            $display("FAIL bc_pass_count got %0d expected %0d", d2_pcnt, STATS ? 1 : 0);
        end
    endtask

    task automatic test_fail_de();
        set_insn(8'h12, 3'd1, 16'h8000, 8'h33, 16'h0200, 16'h0201, 1'b1, 16'h8000, 8'h34);
        tick();
        idle();
        tick();
        vectors++;
        if ({d2_valid, d2_pass, d2_sel} !== 4'b1001) begin
            miscompares++;
            $display("FAIL de_result got %b expected 1001", {d2_valid, d2_pass, d2_sel});
        end
        tick();
        vectors++;
        if ({d2_fail, d3_fail} !== 2'b11) begin
            miscompares++;
            $display("FAIL de_sticky_set got %b expected 11", {d2_fail, d3_fail});
        end
        vectors++;
        if ({d2_pcnt, d2_fcnt} !== (STATS ? {16'd1, 16'd1} : 32'd0)) begin
            miscompares++;
            $display("FAIL de_counts got pass=%0d fail=%0d", d2_pcnt, d2_fcnt);
        end
        tick();
        tick();
        tick();
        vectors++;
        if (d2_fail !== 1'b1) begin
            miscompares++;
            $display("FAIL de_sticky_hold got %b expected 1", d2_fail);
        end
        pulse_clear();
        vectors++;
        if ({d2_fail, d2_pcnt, d2_fcnt, d3_fail, d3_pcnt, d3_fcnt} !== 38'd0) begin
            miscompares++;
            $display("FAIL de_clear got %h expected 0", {d2_fail, d2_pcnt, d2_fcnt, d3_fail, d3_pcnt, d3_fcnt});
        end
    endtask

    task automatic test_hl_wrap();
        set_insn(8'h77, 3'd1, 16'hFFFF, 8'hC3, 16'hFFFF, 16'h0000, 1'b1, 16'hFFFF, 8'hC3);
        tick();
        idle();
        tick();
        vectors++;
        if ({d3_valid, d3_pass, d3_sel} !== 4'b1110) begin
            miscompares++;
            $display("FAIL hl_dut3 got %b expected 1110", {d3_valid, d3_pass, d3_sel});
        end
        vectors++;
        if (d2_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL hl_dut2_ignored got valid=%b expected 0", d2_valid);
        end
        tick();
        vectors++;
        if ({d3_pcnt, d2_pcnt, d3_fail} !== (STATS ? 19'h20000 : 19'd0)) begin
            miscompares++;
            $display("FAIL hl_counts got dut3=%0d dut2=%0d fail=%b", d3_pcnt, d2_pcnt, d3_fail);
        end
    endtask

    task automatic test_ignore();
        set_insn(8'h02, 3'd2, 16'h1234, 8'h5A, 16'h0100, 16'h0102, 1'b1, 16'h1234, 8'h5A);
        tick();
        set_insn(8'h03, 3'd1, 16'h1234, 8'h5A, 16'h0100, 16'h0101, 1'b1, 16'h1234, 8'h5A);
        tick();
        idle();
        vectors++;
        if ({d2_valid, d3_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL ignore_len got %b expected 00", {d2_valid, d3_valid});
        end
        tick();
        vectors++;
        if ({d2_valid, d3_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL ignore_opcode got %b expected 00", {d2_valid, d3_valid});
        end
    endtask

    task automatic test_back_to_back();
        pulse_clear();
        set_insn(8'h02, 3'd1, 16'h1000, 8'h11, 16'h0010, 16'h0011, 1'b1, 16'h1000, 8'h11);
        tick();
        vectors++;
        if (d2_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_early got valid=%b expected 0", d2_valid);
        end
        set_insn(8'h12, 3'd1, 16'h2000, 8'h22, 16'h0011, 16'h0012, 1'b1, 16'h2000, 8'h22);
        tick();
        vectors++;
        if ({d2_valid, d2_pass, d2_sel} !== 4'b1100) begin
            miscompares++;
            $display("FAIL b2b_first got %b expected 1100", {d2_valid, d2_pass, d2_sel});
        end
        set_insn(8'h02, 3'd1, 16'h3000, 8'h44, 16'h0012, 16'h0013, 1'b1, 16'h3000, 8'h44);
        tick();
        idle();
        vectors++;
        if ({d2_valid, d2_pass, d2_sel} !== 4'b1101) begin
            miscompares++;
            $display("FAIL b2b_second got %b expected 1101", {d2_valid, d2_pass, d2_sel});
        end
        tick();
        vectors++;
        if ({d2_valid, d2_pass, d2_sel} !== 4'b1100) begin
            miscompares++;
            $display("FAIL b2b_third got %b expected 1100", {d2_valid, d2_pass, d2_sel});
        end
        tick();
        vectors++;
        if (d2_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_end got valid=%b expected 0", d2_valid);
        end
        vectors++;
        if ({d2_pcnt, d3_pcnt} !== (STATS ? {16'd3, 2'd3} : 18'd0)) begin
            miscompares++;
            $display("FAIL b2b_counts got dut2=%0d dut3=%0d", d2_pcnt, d3_pcnt);
        end
    endtask

    task automatic test_saturate();
        set_insn(8'h02, 3'd1, 16'h1000, 8'h11, 16'h0010, 16'h0011, 1'b1, 16'h1000, 8'h11);
        tick();
        set_insn(8'h02, 3'd1, 16'h3000, 8'h44, 16'h0012, 16'h0013, 1'b1, 16'h3000, 8'h44);
        tick();
        idle();
        tick();
        tick();
        vectors++;
        if ({d2_pcnt, d3_pcnt} !== (STATS ? {16'd5, 2'd3} : 18'd0)) begin
            miscompares++;
            $display("FAIL saturate got dut2=%0d dut3=%0d", d2_pcnt, d3_pcnt);
        end
    endtask

    task automatic test_clear_collision();
        pulse_clear();
        set_insn(8'h02, 3'd1, 16'h1000, 8'h11, 16'h0010, 16'h0011, 1'b1, 16'h1000, 8'h12);
        tick();
        idle();
        tick();
        vectors++;
        if ({d2_valid, d2_pass} !== 2'b10) begin
            miscompares++;
            $display("FAIL collide_result got %b expected 10", {d2_valid, d2_pass});
        end
        chk_clear = 1'b1;
        tick();
        chk_clear = 1'b0;
        tick();
        vectors++;
        if ({d2_fail, d2_fcnt, d3_fail, d3_fcnt} !== 20'd0) begin
            miscompares++;
            $display("FAIL collide_not_latched got %h expected 0", {d2_fail, d2_fcnt, d3_fail, d3_fcnt});
        end
    endtask

    task automatic test_reset_midflight();
        set_insn(8'h02, 3'd1, 16'h1234, 8'h5A, 16'h0100, 16'h0101, 1'b1, 16'h1234, 8'h5A);
        tick();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if ({d2_valid, d3_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL midflight_a got %b expected 00", {d2_valid, d3_valid});
        end
        tick();
        vectors++;
        if ({d2_valid, d3_valid, d2_pcnt} !== 18'd0) begin
            miscompares++;
            $display("FAIL midflight_b got %h expected 0", {d2_valid, d3_valid, d2_pcnt});
        end
    endtask

    task automatic test_no_write();
        set_insn(8'h02, 3'd1, 16'h1234, 8'h5A, 16'h0100, 16'h0101, 1'b0, 16'h1234, 8'h5A);
        tick();
        idle();
        tick();
        vectors++;
        if ({d2_valid, d2_pass, d2_sel} !== 4'b1000) begin
            miscompares++;
            $display("FAIL nowrite_result got %b expected 1000", {d2_valid, d2_pass, d2_sel});
        end
        tick();
        vectors++;
        if ({d2_fail, d2_fcnt} !== {1'b1, (STATS ? 16'd1 : 16'd0)}) begin
            miscompares++;
            $display("FAIL nowrite_sticky got fail=%b count=%0d", d2_fail, d2_fcnt);
        end
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        reset          = 1'b1;
        chk_clear      = 1'b0;
        z80fi_valid    = 1'b0;
        z80fi_insn     = 32'd0;
        z80fi_insn_len = 3'd0;
        z80fi_pc_rdata = 16'd0;
        z80fi_pc_wdata = 16'd0;
        z80fi_ptr_rdata = 16'd0;
        z80fi_a_rdata  = 8'd0;
        z80fi_mem_wr   = 1'b0;
        z80fi_mem_waddr = 16'd0;
        z80fi_mem_wdata = 8'd0;

        test_reset();
        test_pass_bc();
        test_fail_de();
        test_hl_wrap();
        test_ignore();
        test_back_to_back();
        test_saturate();
        test_clear_collision();
        test_reset_midflight();
        test_no_write();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/z80fi_insn_check_ld_ind_rr_a.md
Z80FI_INSN_CHECK_LD_IND_RR_A -- requirements
Module: z80fi_insn_check_ld_ind_rr_a

Interface
REQ-001 SHALL have one clock and synchronous, active-high reset, named clk and reset.
REQ-002 SHALL have parameter NUM_PTR, 2, number of checked pointer registers: 2 = BC,DE; 3 = BC,DE,HL.
REQ-003 SHALL have parameter ADDR_W, 16, pointer and memory address width.
REQ-004 SHALL have parameter CNT_W, 16, statistics counter width.
REQ-005 SHALL have ports: clk  in  1  clock.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 z80fi_valid  in  1  retired-instruction strobe.
REQ-008 z80fi_insn  in  32  instruction bytes, first opcode byte in [7:0].
REQ-009 z80fi_insn_len  in  3  instruction length in bytes.
REQ-010 z80fi_pc_rdata / z80fi_pc_wdata  in  ADDR_W each  PC before/after.
REQ-011 z80fi_ptr_rdata  in  ADDR_W  value of the pointer register selected by REQ-016.
REQ-012 z80fi_a_rdata  in  8  accumulator value before execution.
REQ-013 z80fi_mem_wr  in  1; z80fi_mem_waddr  in  ADDR_W; z80fi_mem_wdata  in  8  actual memory write.
REQ-014 chk_clear  in  1  clears sticky failure and counters.
REQ-015 chk_valid  out  1; chk_pass  out  1; chk_fail  out  1 (sticky); chk_ptr_sel  out  2; pass_count / fail_count  out  CNT_W each.

Function
REQ-016 SHALL decode, when z80fi_valid, insn_len == 1 and opcode 0x02 (BC, sel 0), 0x12 (DE, sel 1), or 0x77 (HL, sel 2, only if NUM_PTR == 3); any other instruction is ignored; 0x77 with NUM_PTR == 2 is ignored.
REQ-017 SHALL be a 2-stage pipeline: stage 1 registers expected {addr = ptr_rdata, data = a_rdata, pc = pc_rdata + 1 mod 2^ADDR_W} and actual {mem_wr, waddr, wdata, pc_wdata} plus sel; stage 2 compares.
REQ-018 SHALL assert chk_valid for exactly one cycle, 2 cycles after the accepted z80fi_valid cycle; chk_ptr_sel = registered sel.
REQ-019 SHALL set chk_pass = 1 iff mem_wr == 1, waddr, wdata and pc_wdata all match expected; chk_pass is 0 whenever chk_valid is 0.
REQ-020 SHALL accept a matching instruction every cycle (back-to-back, no stall); each produces its own chk_valid pulse in order.
REQ-021 SHALL implement state machine RUN / FAILED: RUN -> FAILED on chk_valid with !chk_pass; FAILED -> RUN only on chk_clear or reset; chk_fail = (state == FAILED).
REQ-022 SHALL, on chk_clear, return to RUN and zero counters next cycle; a failing check in the same cycle as chk_clear is reported on chk_valid/chk_pass but SHALL NOT set FAILED or be counted.
REQ-023 SHALL saturate pass_count and fail_count at 2^CNT_W-1 (no wrap).
REQ-024 SHALL compute PC wrap: pc_rdata = 2^ADDR_W-1 expects pc_wdata = 0.

Reset
REQ-025 SHALL on reset clear both pipeline stage valids, drive chk_valid, chk_pass, chk_fail, chk_ptr_sel, pass_count, fail_count to 0, state RUN.
REQ-026 SHALL discard any in-flight check when reset is asserted mid-pipeline; no chk_valid pulse after reset for pre-reset instructions.

Configuration
REQ-027 SHALL, with Z80FI_CHECK_STATS_EN defined, implement pass_count and fail_count per REQ-022/023; without it, both outputs SHALL be constant 0 and no counter registers exist; all other behaviour identical.

Verification
REQ-028 0x02, BC=0x1234, A=0x5A, pc 0x0100->0x0101, write 0x1234/0x5A -> cycle+2 chk_valid=1, chk_pass=1, sel=0, pass_count=1.
REQ-029 0x12, DE=0x8000, A=0x33, actual wdata 0x34 -> chk_pass=0, chk_fail=1 stays high, fail_count=1; chk_clear -> chk_fail=0, counts 0.
REQ-030 0x77, HL=0xFFFF, pc 0xFFFF->0x0000: NUM_PTR=3 -> pass, sel=2; NUM_PTR=2 -> no chk_valid.
REQ-031 three back-to-back 0x02/0x12/0x02 valid cycles -> three consecutive chk_valid pulses, sel 0,1,0.
REQ-032 reset one cycle after accepted instruction -> no chk_valid; 0x02 with z80fi_mem_wr=0 -> fail; CNT_W=2 with 5 passes -> pass_count=3.
